// File: rtl/user_str_tx_buffer.sv
// user_str_tx_buffer: FWFT buffer that cuts a 64-bit user stream into 4 KB-safe MWr bursts for the TX engine.
//  clk_i/rst_i           clock, async active-high reset
//  s_data_i/s_valid_i    user stream in; s_ready_o = FIFO not full
//  dma_start_i           start pulse with dma_base_addr_i/dma_len_i (bytes)
//  str_*                 burst handshake with the TX engine (avail/len/addr/data, rd pop, done pulse)
//  intr_req_o/intr_done_i end-of-transfer interrupt handshake
//  xfer_busy_o, bytes_sent_o, underflow_o  status
module user_str_tx_buffer #(
  parameter int DEPTH_LOG2     = 9,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic        dma_start_i,
  input  logic [31:0] dma_base_addr_i,
  input  logic [31:0] dma_len_i,
  output logic        str_data_avail_o,
  output logic [4:0]  str_len_o,
  output logic [31:0] str_wr_addr_o,
  output logic [63:0] str_data_o,
  input  logic        str_data_rd_i,
  input  logic        str_dma_done_i,
  output logic        intr_req_o,
  input  logic        intr_done_i,
  output logic        xfer_busy_o,
  output logic [31:0] bytes_sent_o,
  output logic        underflow_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_DONE, FINISH} state_t;
  state_t state, state_nx;
  logic [63:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [28:0] rem_qw;
  logic [TW-1:0] timer;
  logic [9:0] qw_to_4k;
  logic [4:0] cap, want, burst;
  logic push, pop, empty, start, fire, done;
  assign empty = count == '0;
  // count never exceeds DEPTH, so its MSB alone flags full
  assign s_ready_o = ~count[DEPTH_LOG2];
  assign push = s_valid_i & s_ready_o;
  assign pop = str_data_rd_i & ~empty;
  assign str_data_o = mem[rd_ptr];
  assign xfer_busy_o = state != IDLE;
  assign intr_req_o = state == FINISH;
  assign start = state == IDLE & dma_start_i;
  assign done = state == WAIT_DONE & str_dma_done_i;
  // addr[2:0] is always zero, so the distance to the next 4 KB page is exact in qwords
  assign qw_to_4k = 10'd512 - {1'b0, str_wr_addr_o[11:3]};
  assign cap = rem_qw < 29'(MAX_BURST) ? rem_qw[4:0] : 5'(MAX_BURST);
  assign want = qw_to_4k < {5'd0, cap} ? qw_to_4k[4:0] : cap;
  assign burst = count >= CW'(want) ? want : count[4:0];
  assign fire = state == ARMED & ~str_data_avail_o
              & (count >= CW'(want) | (timer == TW'(TIMEOUT_CYCLES) & ~empty));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (dma_start_i) state_nx = (dma_len_i >> 3) == 32'd0 ? FINISH : ARMED;
      ARMED:     if (str_data_avail_o & str_data_rd_i) state_nx = WAIT_DONE;
      WAIT_DONE: if (str_dma_done_i) state_nx = rem_qw == {24'd0, str_len_o} ? FINISH : ARMED;
      default:   if (intr_done_i) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= s_data_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      underflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (str_data_rd_i & empty) underflow_o <= 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      str_wr_addr_o <= '0;
      rem_qw <= '0;
      bytes_sent_o <= '0;
      timer <= '0;
      str_data_avail_o <= 1'b0;
      str_len_o <= '0;
    end else begin
      timer <= (push | fire | start) ? '0 : timer == TW'(TIMEOUT_CYCLES) ? timer : timer + TW'(1);
      if (start) begin
        str_wr_addr_o <= dma_base_addr_i & ~32'd7;
        rem_qw <= 29'(dma_len_i >> 3);
        bytes_sent_o <= '0;
      end
      if (fire) begin
        str_data_avail_o <= 1'b1;
        str_len_o <= burst;
      end else if (str_data_avail_o & str_data_rd_i) str_data_avail_o <= 1'b0;
      if (done) begin
        str_wr_addr_o <= str_wr_addr_o + {24'd0, str_len_o, 3'b0};
        rem_qw <= rem_qw - {24'd0, str_len_o};
        bytes_sent_o <= bytes_sent_o + {24'd0, str_len_o, 3'b0};
      end
    end
  end
endmodule
